subpixel_interp_stream: RTL and testbench

//  Parametrised successor to the fixed 8-pixel HEVC luma interpolator.

---
 rtl/subpixel_interp_stream.sv | 195 +++++++++++++++++++
 tb/tb_subpixel_interp_stream.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subpixel_interp_stream.sv
// Streaming separable 8-tap HEVC luma interpolator: per-row horizontal filter,
// eight-row window, vertical filter into a single valid/ready output register.
module subpixel_interp_stream #(
    parameter int NUM_PIX = 8,
    parameter int PIX_W   = 8,
    parameter int BLK_H   = 8,
    localparam int IDX_W  = (BLK_H > 1) ? $clog2(BLK_H) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   frac_x,
    input  logic [1:0]                   frac_y,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [(NUM_PIX+7)*PIX_W-1:0] in_row,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_PIX*PIX_W-1:0]     out_row,
    output logic [IDX_W-1:0]             out_row_idx,
    output logic                         busy,
    output logic                         done
);

    localparam int ROW_W = NUM_PIX * PIX_W;
    localparam int SUM_W = PIX_W + 8;
    localparam int CNT_W = (IDX_W > 3) ? IDX_W : 3;
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(6);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(BLK_H - 1);
    localparam logic signed [SUM_W-1:0] MAX_PIX = SUM_W'((1 << PIX_W) - 1);

    // Tap j sits at [j*8 +: 8], two's complement.
    localparam logic [63:0] TAPS_A = {8'h00, 8'h01, 8'hFB, 8'h11, 8'h3A, 8'hF6, 8'h04, 8'hFF};
    localparam logic [63:0] TAPS_B = {8'hFF, 8'h04, 8'hF5, 8'h28, 8'h28, 8'hF5, 8'h04, 8'hFF};
    localparam logic [63:0] TAPS_C = {8'hFF, 8'h04, 8'hF6, 8'h3A, 8'h11, 8'hFB, 8'h01, 8'h00};

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [1:0]               r_frac_x;
    logic [1:0]               r_frac_y;
    logic [CNT_W-1:0]         r_cnt;
    logic [8*ROW_W-1:0]       r_win;
    logic                     r_out_valid;
    logic [ROW_W-1:0]         r_out_row;
    logic [IDX_W-1:0]         r_out_idx;
    logic [ROW_W-1:0]         w_hrow;
    logic [ROW_W-1:0]         w_vrow;
    logic                     w_accept;
    logic                     w_load;
    logic                     w_out_hs;

    function automatic logic signed [7:0] coef(input logic [1:0] frac, input int j);
        logic signed [7:0] c;
        case (frac)
            2'd1:    c = TAPS_A[j*8 +: 8];
            2'd2:    c = TAPS_B[j*8 +: 8];
            2'd3:    c = TAPS_C[j*8 +: 8];
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [PIX_W-1:0] round_clip(input logic signed [SUM_W-1:0] acc);
        logic signed [SUM_W-1:0] r;
        logic [PIX_W-1:0]        res;
        r = (acc + SUM_W'(32)) >>> 6;
        if (r[SUM_W-1])
            res = '0;
        else if (r > MAX_PIX)
            res = MAX_PIX[PIX_W-1:0];
        else
            res = r[PIX_W-1:0];
        return res;
    endfunction

    // Integer position is a straight copy of the centre tap, no rounding.
    function automatic logic [PIX_W-1:0] filt8(input logic [8*PIX_W-1:0] px, input logic [1:0] frac);
        logic signed [SUM_W-1:0] acc;
        logic signed [SUM_W-1:0] p;
        logic signed [SUM_W-1:0] c;
        logic [PIX_W-1:0]        res;
        acc = '0;
        for (int j = 0; j < 8; j++) begin
            p   = SUM_W'(px[j*PIX_W +: PIX_W]);
            c   = SUM_W'(coef(frac, j));
            acc = acc + p * c;
        end
        if (frac == 2'd0)
            res = px[3*PIX_W +: PIX_W];
        else
            res = round_clip(acc);
        return res;
    endfunction

    assign w_out_hs  = r_out_valid & out_ready;
    assign in_ready  = ((r_state == S_FILL) || (r_state == S_RUN)) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid & in_ready;
    assign w_load    = w_accept && (r_state == S_RUN);
    assign out_valid = r_out_valid;
    assign out_row   = r_out_row;
    assign out_row_idx = r_out_idx;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DRAIN) && w_out_hs;

    always_comb begin
        w_hrow = '0;
        for (int i = 0; i < NUM_PIX; i++)
            w_hrow[i*PIX_W +: PIX_W] = filt8(in_row[i*PIX_W +: 8*PIX_W], r_frac_x);
    end

    // Vertical taps 0..6 come from window rows 1..7; tap 7 is the row being accepted.
    always_comb begin
        logic [8*PIX_W-1:0] col;
        w_vrow = '0;
        col    = '0;
        for (int i = 0; i < NUM_PIX; i++) begin
            for (int j = 0; j < 7; j++)
                col[j*PIX_W +: PIX_W] = r_win[(j+1)*ROW_W + i*PIX_W +: PIX_W];
            col[7*PIX_W +: PIX_W] = w_hrow[i*PIX_W +: PIX_W];
            w_vrow[i*PIX_W +: PIX_W] = filt8(col, r_frac_y);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_FILL;
            S_FILL:  if (w_accept && (r_cnt == FILL_LAST)) w_state_nxt = S_RUN;
            S_RUN:   if (w_accept && (r_cnt == RUN_LAST)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_out_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frac_x <= '0;
            r_frac_y <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_frac_x <= frac_x;
            r_frac_y <= frac_y;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            if (((r_state == S_FILL) && (r_cnt == FILL_LAST)) ||
                ((r_state == S_RUN) && (r_cnt == RUN_LAST)))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // Newest horizontally filtered row enters at the top (row 7).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_win <= '0;
        else if (w_accept)
            r_win <= {w_hrow, r_win[8*ROW_W-1:ROW_W]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_row   <= '0;
            r_out_idx   <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_row   <= w_vrow;
            r_out_idx   <= r_cnt[IDX_W-1:0];
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_subpixel_interp_stream.sv
// Randomised stream bench for subpixel_interp_stream against a 2-D array model
// of the separable HEVC luma filter.
module tb_subpixel_interp_stream;

    localparam int NP = 8;
    localparam int PW = 8;
    localparam int BH = 8;
    localparam int NR = BH + 7;
    localparam int IW = (NP + 7) * PW;
    localparam int OW = NP * PW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    frac_x = '0;
    logic [1:0]    frac_y = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_row = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_row;
    logic [2:0]    out_row_idx;
    logic          busy;
    logic          done;

    subpixel_interp_stream #(.NUM_PIX(NP), .PIX_W(PW), .BLK_H(BH)) dut (
        .clk(clk), .rst(rst), .start(start), .frac_x(frac_x), .frac_y(frac_y),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_row_idx(out_row_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail = 0;
    int            pix[NR][NP+7];
    logic [OW-1:0] exp_row_q[$];
    int            exp_idx_q[$];
    int            done_cnt = 0;
    int            hs_cnt = 0;
    int            ready_pct = 75;
    int            valid_pct = 75;
    bit            stall = 0;
    bit            abort = 0;
    bit            prev_hold = 0;
    logic [OW-1:0] prev_row;
    logic [2:0]    prev_idx;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic int tap(int f, int j);
        int a[8] = '{-1, 4, -10, 58, 17, -5, 1, 0};
        int b[8] = '{-1, 4, -11, 40, 40, -11, 4, -1};
        if (f == 1) return a[j];
        if (f == 2) return b[j];
        return a[7-j];
    endfunction

    function automatic int filt(int p[8], int f);
        int s;
        if (f == 0) return p[3];
        s = 0;
        for (int j = 0; j < 8; j++) s += tap(f, j) * p[j];
        s = (s + 32) >>> 6;
        if (s < 0) s = 0;
        if (s > (1 << PW) - 1) s = (1 << PW) - 1;
        return s;
    endfunction

    function automatic logic [IW-1:0] pack_row(int r);
        logic [IW-1:0] v;
        v = '0;
        for (int c = 0; c < NP + 7; c++) v[c*PW +: PW] = PW'(pix[r][c]);
        return v;
    endfunction

    task automatic build_expected(int fx, int fy);
        int h[NR][NP];
        int p[8];
        logic [OW-1:0] row;
        for (int r = 0; r < NR; r++)
            for (int i = 0; i < NP; i++) begin
                for (int j = 0; j < 8; j++) p[j] = pix[r][i+j];
                h[r][i] = filt(p, fx);
            end
        for (int k = 0; k < BH; k++) begin
            row = '0;
            for (int i = 0; i < NP; i++) begin
                for (int j = 0; j < 8; j++) p[j] = h[k+j][i];
                row[i*PW +: PW] = PW'(filt(p, fy));
            end
            exp_row_q.push_back(row);
            exp_idx_q.push_back(k);
        end
    endtask

    // Sink: random out_ready, forced low while stalled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Compare process: every output handshake against the model queue.
    always @(negedge clk) begin
        logic hs;
        logic want_done;
        logic [OW-1:0] er;
        int ei;
        if (!rst) begin
            prev_hold = 0;
        end else begin
            hs = out_valid && out_ready;
            want_done = 1'b0;
            if (prev_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_row", out_row, prev_row);
                check("hold_idx", out_row_idx, prev_idx);
            end
            if (out_valid && !out_ready) check("backpressure_in_ready", in_ready, 0);
            if (hs) begin
                if (exp_row_q.size() == 0) begin
                    check("unexpected_row", 1, 0);
                end else begin
                    er = exp_row_q.pop_front();
                    ei = exp_idx_q.pop_front();
                    want_done = (ei == BH - 1);
                    check("out_row", out_row, er);
                    check("out_row_idx", out_row_idx, ei);
                end
                hs_cnt++;
            end
            if (hs || done) check("done", done, want_done);
            if (done) done_cnt++;
            prev_hold = out_valid && !out_ready;
            prev_row  = out_row;
            prev_idx  = out_row_idx;
        end
    end

    task automatic feed_rows();
        int r = 0;
        int guard = 0;
        bit acc;
        in_row = pack_row(0);
        in_valid = ($urandom_range(0, 99) < valid_pct);
        while (r < NR && !abort && guard < 4000) begin
            @(negedge clk);
            acc = in_valid && in_ready && rst;
            @(posedge clk);
            #1;
            guard++;
            if (acc) r++;
            if (r < NR) begin
                in_row = pack_row(r);
                in_valid = ($urandom_range(0, 99) < valid_pct);
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        if (!abort) check("rows_accepted", r, NR);
    endtask

    task automatic wait_hs(int n);
        int g = 0;
        while (hs_cnt < n && g < 3000) begin
            @(posedge clk);
            g++;
        end
        if (g >= 3000) check("handshake_timeout", hs_cnt, n);
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((busy || exp_row_q.size() != 0) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check("rows_left", exp_row_q.size(), 0);
        check("busy_end", busy, 0);
    endtask

    task automatic disturb(int mode, int base, int fx, int fy);
        if (mode == 1) begin
            wait_hs(base + 3);
            @(negedge clk);
            stall = 1;
            repeat (5) begin
                @(negedge clk);
                check("stall_out_valid", out_valid, 1);
                check("stall_in_ready", in_ready, 0);
            end
            stall = 0;
        end else if (mode == 2) begin
            wait_hs(base + 3);
            @(negedge clk);
            #2;
            rst = 1'b0;
            abort = 1;
            #1;
            check("rst_out_valid", out_valid, 0);
            check("rst_out_row", out_row, 0);
            check("rst_out_idx", out_row_idx, 0);
            check("rst_busy", busy, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_done", done, 0);
            exp_row_q.delete();
            exp_idx_q.delete();
            @(posedge clk);
            #2;
            rst = 1'b1;
            @(negedge clk);
            check("post_rst_busy", busy, 0);
            check("post_rst_out_valid", out_valid, 0);
        end else if (mode == 3) begin
            wait_hs(base + 2);
            @(posedge clk);
            #1;
            frac_x = 2'(3 - fx);
            frac_y = 2'(3 - fy);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic run_block(int fx, int fy, int mode);
        int d0 = done_cnt;
        int base = hs_cnt;
        abort = 0;
        @(posedge clk);
        #1;
        frac_x = 2'(fx);
        frac_y = 2'(fy);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        frac_x = 2'($urandom);
        frac_y = 2'($urandom);
        check("busy_after_start", busy, 1);
        fork
            feed_rows();
            disturb(mode, base, fx, fy);
        join
        if (mode != 2) begin
            wait_idle();
            check("done_once", done_cnt - d0, 1);
        end
        abort = 0;
    endtask

    task automatic fill_random();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NP + 7; c++)
                pix[r][c] = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) * 255) : $urandom_range(0, 255);
    endtask

    initial begin
        int p[8];
        logic [OW-1:0] er;
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p[8];
        logic [OW-1:0] er;

        #3 rst = 1'b0;
        #2;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_row", out_row, 0);
        check("reset_out_idx", out_row_idx, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_in_ready", in_ready, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        p = '{0, 0, 0, 0, 255, 255, 255, 255};
        check("model_b_edge", filt(p, 2), 128);
        p = '{255, 255, 255, 0, 0, 0, 0, 0};
        check("model_b_negclip", filt(p, 2), 0);
        p = '{0, 0, 0, 64, 0, 0, 0, 0};
        check("model_a_centre", filt(p, 1), 58);
        check("model_c_centre", filt(p, 3), 17);

        // 1: flat field
        for (int r = 0; r < NR; r++) for (int c = 0; c < NP + 7; c++) pix[r][c] = 100;
        build_expected(2, 2);
        check("model_flat", exp_row_q[0], {NP{8'd100}});
        run_block(2, 2, 0);

        // 2: integer bypass
        for (int r = 0; r < NR; r++) for (int c = 0; c < NP + 7; c++) pix[r][c] = (10 * c + r) % 256;
        build_expected(0, 0);
        for (int k = 0; k < BH; k += 7) begin
            er = exp_row_q[k];
            for (int i = 0; i < NP; i += 3) check("model_bypass", er[i*PW +: PW], 10 * (i + 3) + k + 3);
        end
        run_block(0, 0, 0);

        // 3: clipping
        for (int r = 0; r < NR; r++) for (int c = 0; c < NP + 7; c++) pix[r][c] = (c < 4) ? 0 : 255;
        build_expected(2, 0);
        er = exp_row_q[BH-1];
        check("model_clip_p0", er[0 +: PW], 128);
        check("model_clip_p1", er[PW +: PW], 255);
        run_block(2, 0, 0);

        // 4: backpressure mid-RUN
        valid_pct = 100;
        fill_random();
        build_expected(1, 3);
        run_block(1, 3, 1);
        valid_pct = 75;

        // 5: asynchronous reset mid-RUN, then a clean block
        fill_random();
        build_expected(3, 2);
        run_block(3, 2, 2);
        fill_random();
        build_expected(2, 1);
        run_block(2, 1, 0);

        // 6: start pulsed during RUN with different frac
        fill_random();
        build_expected(1, 2);
        run_block(1, 2, 3);

        for (int t = 0; t < 6; t++) begin
            int fx;
            int fy;
            fx = $urandom_range(0, 3);
            fy = $urandom_range(0, 3);
            ready_pct = $urandom_range(30, 100);
            valid_pct = $urandom_range(30, 100);
            fill_random();
            build_expected(fx, fy);
            run_block(fx, fy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
